fft8_stage_sequencer: RTL and testbench

//  Sequences the three radix-2 butterfly stages of the 8-point FFT/IFFT datapath.
//  - Accepts a start request from the RISC-V core interface.
//  - Issues a one-cycle valid strobe to each stage in turn and waits for that stage's ready before moving on.
//  - Drives the IFFT conjugate/scale controls and reports busy/done/error.
//  - Counts completed frames.

---
 rtl/fft8_stage_sequencer.sv | 148 ++++++++++++++
 tb/tb_fft8_stage_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fft8_stage_sequencer.sv
// Sequencer for the three radix-2 butterfly stages of the 8-point FFT/IFFT datapath.
// Strobes each stage in turn, waits for its ready, and reports busy/done/error plus a frame count.
module fft8_stage_sequencer #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TO_W    = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fft_start,
  input  logic             fft_mode,
  input  logic             butterfly1_ready,
  input  logic             butterfly2_ready,
  input  logic             butterfly3_ready,
  output logic             butterfly1_valid,
  output logic             butterfly2_valid,
  output logic             butterfly3_valid,
  output logic             conj_en,
  output logic [2:0]       scale_shift,
  output logic             fft_busy,
  output logic             fft_done,
  output logic             fft_error,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  localparam int unsigned IDX_W = 2;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               mode_q, mode_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [2:0]         valid_q, valid_d;
  logic [2:0]         scale_q, scale_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               stage_ready;

  // Only the ready of the stage currently being waited on matters.
  always_comb begin
    stage_ready = 1'b0;
    case (idx_q)
      2'd1:    stage_ready = butterfly1_ready;
      2'd2:    stage_ready = butterfly2_ready;
      2'd3:    stage_ready = butterfly3_ready;
      default: stage_ready = 1'b0;
    endcase
  end

  // Next-state logic; every output flop is loaded from the next-state view so
  // strobes line up with the registered state and clear together on reset.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mode_d      = mode_q;
    to_cnt_d    = to_cnt_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      S_IDLE, S_ERR: begin
        if (fft_start) begin
          state_d = S_ISSUE;
          idx_d   = IDX_W'(1);
          mode_d  = fft_mode;
        end
      end
      S_ISSUE: begin
        state_d  = S_WAIT;
        to_cnt_d = '0;
      end
      S_WAIT: begin
        if (stage_ready) begin
          if (idx_q == IDX_W'(3)) begin
            state_d     = S_DONE;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
          end else begin
            state_d = S_ISSUE;
            idx_d   = idx_q + IDX_W'(1);
          end
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    valid_d[0] = (state_d == S_ISSUE) && (idx_d == IDX_W'(1));
    valid_d[1] = (state_d == S_ISSUE) && (idx_d == IDX_W'(2));
    valid_d[2] = (state_d == S_ISSUE) && (idx_d == IDX_W'(3));
    busy_d     = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_DONE);
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERR);
    scale_d    = mode_d ? 3'd3 : 3'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= IDX_W'(1);
      mode_q      <= 1'b0;
      to_cnt_q    <= '0;
      frame_cnt_q <= '0;
      valid_q     <= '0;
      scale_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      to_cnt_q    <= to_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      valid_q     <= valid_d;
      scale_q     <= scale_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign butterfly1_valid = valid_q[0];
  assign butterfly2_valid = valid_q[1];
  assign butterfly3_valid = valid_q[2];
  assign conj_en          = mode_q;
  assign scale_shift      = scale_q;
  assign fft_busy         = busy_q;
  assign fft_done         = done_q;
  assign fft_error        = error_q;
  assign frame_cnt        = frame_cnt_q;

endmodule

// File: tb/tb_fft8_stage_sequencer.sv
// Directed bench for fft8_stage_sequencer: nominal, IFFT, stall, timeout, reset and wrap cases.
module tb_fft8_stage_sequencer;

  logic       clk;
  logic       rst;
  logic       fft_start;
  logic       fft_mode;
  logic       butterfly1_ready;
  logic       butterfly2_ready;
  logic       butterfly3_ready;
  logic       butterfly1_valid;
  logic       butterfly2_valid;
  logic       butterfly3_valid;
  logic       conj_en;
  logic [2:0] scale_shift;
  logic       fft_busy;
  logic       fft_done;
  logic       fft_error;
  logic [7:0] frame_cnt;

  int         n_checks;
  int         n_err;
  logic [7:0] exp_frames;
  int         dones;

  fft8_stage_sequencer #(.TIMEOUT(15), .TO_W(4), .CNT_W(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .fft_start        (fft_start),
    .fft_mode         (fft_mode),
    .butterfly1_ready (butterfly1_ready),
    .butterfly2_ready (butterfly2_ready),
    .butterfly3_ready (butterfly3_ready),
    .butterfly1_valid (butterfly1_valid),
    .butterfly2_valid (butterfly2_valid),
    .butterfly3_valid (butterfly3_valid),
    .conj_en          (conj_en),
    .scale_shift      (scale_shift),
    .fft_busy         (fft_busy),
    .fft_done         (fft_done),
    .fft_error        (fft_error),
    .frame_cnt        (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are then stable and inputs set now apply to this cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] valids();
    return 32'({butterfly3_valid, butterfly2_valid, butterfly1_valid});
  endfunction

  // One frame starting in the current cycle (c0). dK = cycles from valid K to ready K.
  task automatic do_frame(input logic mode, input int d1, input int d2, input int d3,
                          input int flip_c, input logic hold);
    int v1, v2, v3, dn;
    v1 = 1;
    v2 = v1 + d1 + 1;
    v3 = v2 + d2 + 1;
    dn = v3 + d3 + 1;
    fft_start        = 1'b1;
    fft_mode         = mode;
    butterfly1_ready = 1'b0;
    butterfly2_ready = 1'b0;
    butterfly3_ready = 1'b0;
    step();
    exp_frames = exp_frames + 8'd1;
    for (int c = 1; c <= dn + 1; c++) begin
      fft_start        = hold && (c <= dn);
      if (c == flip_c) fft_mode = ~mode;
      butterfly1_ready = (c == v1 + d1);
      butterfly2_ready = (c == v2 + d2);
      butterfly3_ready = (c == v3 + d3);
      check("valid", valids(), 32'({c == v3, c == v2, c == v1}));
      check("busy", 32'(fft_busy), 32'(c <= dn));
      check("done", 32'(fft_done), 32'(c == dn));
      check("error", 32'(fft_error), 32'd0);
      check("conj_en", 32'(conj_en), 32'(mode));
      check("scale", 32'(scale_shift), mode ? 32'd3 : 32'd0);
      if (c == dn + 1) check("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
      step();
    end
    butterfly1_ready = 1'b0;
    butterfly2_ready = 1'b0;
    butterfly3_ready = 1'b0;
    fft_start        = 1'b0;
  endtask

  initial begin
    n_checks         = 0;
    n_err            = 0;
    exp_frames       = 8'd0;
    dones            = 0;
    rst              = 1'b1;
    fft_start        = 1'b0;
    fft_mode         = 1'b0;
    butterfly1_ready = 1'b0;
    butterfly2_ready = 1'b0;
    butterfly3_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_valid", valids(), 32'd0);
    check("rst_busy", 32'(fft_busy), 32'd0);
    check("rst_done", 32'(fft_done), 32'd0);
    check("rst_error", 32'(fft_error), 32'd0);
    check("rst_conj", 32'(conj_en), 32'd0);
    check("rst_scale", 32'(scale_shift), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    step();

    // Nominal FFT frame, then IFFT with mode dropped in c2.
    do_frame(1'b0, 1, 1, 1, 0, 1'b0);
    do_frame(1'b1, 1, 1, 1, 2, 1'b0);
    check("ifft_conj_held", 32'(conj_en), 32'd1);
    check("ifft_scale_held", 32'(scale_shift), 32'd3);
    // Stage 2 ready late by 5 cycles, then ready landing on the last timeout cycle.
    do_frame(1'b0, 1, 6, 1, 0, 1'b0);
    do_frame(1'b0, 1, 15, 1, 0, 1'b0);
    // Start held through the whole frame must not queue a second one.
    do_frame(1'b0, 1, 1, 1, 0, 1'b1);
    check("hold_idle_busy", 32'(fft_busy), 32'd0);

    // Stage 2 ready never returns.
    fft_start = 1'b1;
    fft_mode  = 1'b0;
    step();
    fft_start = 1'b0;
    check("to_valid1", valids(), 32'd1);
    step();
    butterfly1_ready = 1'b1;
    step();
    butterfly1_ready = 1'b0;
    check("to_valid2", valids(), 32'd2);
    for (int i = 0; i < 15; i++) step();
    check("to_c18_busy", 32'(fft_busy), 32'd1);
    check("to_c18_error", 32'(fft_error), 32'd0);
    step();
    check("to_c19_error", 32'(fft_error), 32'd1);
    check("to_c19_busy", 32'(fft_busy), 32'd0);
    check("to_c19_valid", valids(), 32'd0);
    step();
    check("to_err_hold", 32'(fft_error), 32'd1);
    check("to_err_cnt", 32'(frame_cnt), 32'(exp_frames));
    do_frame(1'b0, 1, 1, 1, 0, 1'b0);

    // Reset in c4 of an IFFT frame.
    fft_start        = 1'b1;
    fft_mode         = 1'b1;
    butterfly1_ready = 1'b1;
    butterfly2_ready = 1'b1;
    butterfly3_ready = 1'b1;
    step();
    fft_start = 1'b0;
    step();
    step();
    step();
    check("rm_c4_busy", 32'(fft_busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    butterfly1_ready = 1'b0;
    butterfly2_ready = 1'b0;
    butterfly3_ready = 1'b0;
    check("rm_valid", valids(), 32'd0);
    check("rm_busy", 32'(fft_busy), 32'd0);
    check("rm_done", 32'(fft_done), 32'd0);
    check("rm_conj", 32'(conj_en), 32'd0);
    check("rm_scale", 32'(scale_shift), 32'd0);
    check("rm_frame_cnt", 32'(frame_cnt), 32'd0);
    exp_frames = 8'd0;
    step();
    do_frame(1'b0, 1, 1, 1, 0, 1'b0);

    // 256 back-to-back frames with start and all readies held high.
    rst = 1'b1;
    step();
    rst              = 1'b0;
    fft_start        = 1'b1;
    fft_mode         = 1'b0;
    butterfly1_ready = 1'b1;
    butterfly2_ready = 1'b1;
    butterfly3_ready = 1'b1;
    step();
    for (int c = 1; c <= 2047; c++) begin
      if (fft_done) dones++;
      if (c == 1 || c == 9 || c == 2041) check("b2b_valid1", valids(), 32'd1);
      if (c == 8) check("b2b_gap_busy", 32'(fft_busy), 32'd0);
      if (c == 2040) check("b2b_cnt_255", 32'(frame_cnt), 32'd255);
      if (c == 2047) begin
        check("b2b_last_done", 32'(fft_done), 32'd1);
        fft_start = 1'b0;
      end
      step();
    end
    check("b2b_dones", 32'(dones), 32'd256);
    check("b2b_cnt_wrap", 32'(frame_cnt), 32'd0);
    check("b2b_idle", 32'(fft_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
